// File: rtl/dnn_ulaw_loader.sv
// ----------------------------------------------------------------------------
// dnn_ulaw_loader
//
// Host-side front end of the ReLU/u-law inference engine. It accepts one
// grayscale image as a byte stream and writes it into activation RAM. It then
// writes the bias "one" slot, clears and starts the engine, and waits for the
// engine to finish. Last, it streams the ten signed class scores back out.
//
// Ports
//   clk        : clock; all logic uses the rising edge
//   rst        : synchronous, active-high reset
//   s_valid    : pixel byte valid
//   s_data     : unsigned pixel (0..255)
//   s_last     : marks the final byte of an image
//   s_ready    : loader accepts a pixel this cycle
//   wr_en      : activation RAM write strobe
//   wr_addr    : activation RAM write address
//   wr_data    : signed activation byte
//   eng_reset  : one-cycle soft clear to the engine
//   eng_start  : one-cycle start pulse to the engine
//   eng_done   : engine finished, eng_out is valid
//   eng_out    : ten signed 8-bit scores; score i is eng_out[8*i +: 8]
//   res_valid  : result byte valid
//   res_idx    : class index (0..9) of res_data
//   res_data   : signed score for res_idx
//   res_ready  : downstream accepts the result
//   busy       : high in every state except IDLE
//   err_len    : sticky flag, set when the last image had the wrong length
// ----------------------------------------------------------------------------
module dnn_ulaw_loader #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = 16'h0000,
  parameter int                    N_PIX       = 400,
  parameter logic signed [7:0]     ONE_VAL     = 8'sd64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  eng_reset,
  output logic                  eng_start,
  input  logic                  eng_done,
  input  logic [79:0]           eng_out,
  output logic                  res_valid,
  output logic [3:0]            res_idx,
  output logic [7:0]            res_data,
  input  logic                  res_ready,
  output logic                  busy,
  output logic                  err_len
);

  localparam int                    CW        = $clog2(N_PIX + 1);
  localparam logic [CW-1:0]         LAST_IDX  = CW'(N_PIX - 1);
  localparam logic [ADDR_WIDTH-1:0] BIAS_ADDR = ADDR_BASE_A + ADDR_WIDTH'(N_PIX);
  localparam int                    N_CLS     = 10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DISCARD, S_BIAS, S_ENG_RST, S_ENG_GO, S_RUN, S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_len_q, err_len_d;
  logic [3:0]    res_idx_q, res_idx_d;
  logic          capture;

  logic [7:0]    eng_bytes [N_CLS];
  logic [7:0]    score_q   [N_CLS];

  // Slice the flat engine bus into per-class bytes.
  genvar gi;
  generate
    for (gi = 0; gi < N_CLS; gi++) begin : g_unpack
      assign eng_bytes[gi] = eng_out[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      err_len_q <= 1'b0;
      res_idx_q <= 4'd0;
      for (int i = 0; i < N_CLS; i++) score_q[i] <= 8'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      err_len_q <= err_len_d;
      res_idx_q <= res_idx_d;
      if (capture) begin
        for (int i = 0; i < N_CLS; i++) score_q[i] <= eng_bytes[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    err_len_d = err_len_q;
    res_idx_d = res_idx_q;
    capture   = 1'b0;
    s_ready   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = ADDR_BASE_A;
    wr_data   = 8'd0;
    eng_reset = 1'b0;
    eng_start = 1'b0;
    res_valid = 1'b0;
    res_data  = 8'd0;

    case (state_q)
      // IDLE and LOAD share the write path. In IDLE count_q is always zero,
      // so the first pixel of an image lands on ADDR_BASE_A.
      S_IDLE, S_LOAD: begin
        s_ready = 1'b1;
        wr_addr = ADDR_BASE_A + ADDR_WIDTH'(count_q);
        if (s_valid) begin
          wr_en   = 1'b1;
          wr_data = {1'b0, s_data[7:1]};
          if (state_q == S_IDLE) err_len_d = 1'b0;
          count_d = count_q + 1'b1;
          state_d = S_LOAD;
          if (count_q == LAST_IDX) begin
            count_d = '0;
            if (s_last) begin
              state_d = S_BIAS;
            end else begin
              // Too long: swallow the rest up to s_last.
              err_len_d = 1'b1;
              state_d   = S_DISCARD;
            end
          end else if (s_last) begin
            // Too short: the image is abandoned and the engine is not started.
            count_d   = '0;
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end

      S_DISCARD: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_d = S_IDLE;
      end

      S_BIAS: begin
        wr_en   = 1'b1;
        wr_addr = BIAS_ADDR;
        wr_data = ONE_VAL;
        state_d = S_ENG_RST;
      end

      S_ENG_RST: begin
        eng_reset = 1'b1;
        state_d   = S_ENG_GO;
      end

      S_ENG_GO: begin
        eng_start = 1'b1;
        state_d   = S_RUN;
      end

      S_RUN: begin
        if (eng_done) begin
          capture   = 1'b1;
          res_idx_d = 4'd0;
          state_d   = S_DRAIN;
        end
      end

      S_DRAIN: begin
        res_valid = 1'b1;
        res_data  = score_q[res_idx_q];
        if (res_ready) begin
          if (res_idx_q == 4'(N_CLS - 1)) begin
            res_idx_d = 4'd0;
            state_d   = S_IDLE;
          end else begin
            res_idx_d = res_idx_q + 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // While reset is held, every output shows its reset value. This means a
    // reset in mid-operation cannot leak a write or an engine pulse.
    if (rst) begin
      s_ready   = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = ADDR_BASE_A;
      wr_data   = 8'd0;
      eng_reset = 1'b0;
      eng_start = 1'b0;
      res_valid = 1'b0;
      res_data  = 8'd0;
    end
  end

  assign busy    = (state_q != S_IDLE) && !rst;
  assign err_len = err_len_q && !rst;
  assign res_idx = rst ? 4'd0 : res_idx_q;

endmodule
